// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one 8/16-bit frame per accepted request, mode/baud/order latched at accept.
// CS-low time is H*(2+2N) clk cycles; requests are taken only in IDLE (o_tx_ready), never queued.
module spi_shift_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic [2:0]  BR,
   input  logic        DFF,
   input  logic        LSBFIRST,
   input  logic [15:0] i_tx_data,
   input  logic        i_tx_valid,
   output logic        o_tx_ready,
   output logic        o_rx_valid,
   output logic [15:0] o_rx_data,
   output logic        o_busy,
   output logic        SPI_SCK,
   output logic        SPI_MOSI,
   output logic        SPI_CS,
   input  logic        SPI_MISO
);

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  edge_q, edge_d;
   logic [3:0]  txcnt_q, txcnt_d;
   logic [15:0] tx_q, tx_d;
   logic [15:0] rx_sh_q, rx_sh_d;
   logic [15:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        cs_q, cs_d;
   logic        cpol_q, cpol_d;
   logic        cpha_q, cpha_d;
   logic [2:0]  br_q, br_d;
   logic        dff_q, dff_d;
   logic        lsb_q, lsb_d;

   logic [7:0]  hm1;
   logic        term;
   logic [5:0]  last_edge;
   logic [3:0]  msb_idx;
   logic [3:0]  tx_idx;
   logic        next_bit;
   logic        first_bit;
   logic        sample_now;
   logic [15:0] rx_shifted;

   assign hm1        = (8'd1 << br_q) - 8'd1;
   assign term       = (cnt_q == hm1);
   assign last_edge  = dff_q ? 6'd32 : 6'd16;
   assign msb_idx    = dff_q ? 4'd15 : 4'd7;
   assign tx_idx     = lsb_q ? txcnt_q : (msb_idx - txcnt_q);
   assign next_bit   = tx_q[tx_idx];
   assign first_bit  = LSBFIRST ? i_tx_data[0] : (DFF ? i_tx_data[15] : i_tx_data[7]);
   // Each XFER cycle with cnt_q==0 is the cycle in which edge number edge_q is visible on SCK.
   assign sample_now = (state_q == S_XFER) && (cnt_q == 8'd0) && (edge_q[0] ^ cpha_q);
   assign rx_shifted = lsb_q ? (dff_q ? {SPI_MISO, rx_sh_q[15:1]} : {8'h00, SPI_MISO, rx_sh_q[7:1]})
                             : {rx_sh_q[14:0], SPI_MISO};

   always_comb begin
      state_d    = state_q;
      cnt_d      = term ? 8'd0 : cnt_q + 8'd1;
      edge_d     = edge_q;
      txcnt_d    = txcnt_q;
      tx_d       = tx_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      br_d       = br_q;
      dff_d      = dff_q;
      lsb_d      = lsb_q;
      if (sample_now) rx_sh_d = rx_shifted;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (i_tx_valid) begin
               state_d = S_LEAD;
               cpol_d  = CPOL;
               cpha_d  = CPHA;
               br_d    = BR;
               dff_d   = DFF;
               lsb_d   = LSBFIRST;
               tx_d    = i_tx_data;
               sck_d   = CPOL;
               cs_d    = 1'b0;
               mosi_d  = CPHA ? 1'b0 : first_bit;
               txcnt_d = CPHA ? 4'd0 : 4'd1;
               edge_d  = 6'd0;
               rx_sh_d = 16'h0000;
            end
         end
         S_LEAD: begin
            if (term) begin
               state_d = S_XFER;
               cnt_d   = 8'd0;
               sck_d   = ~sck_q;
               edge_d  = 6'd1;
               if (cpha_q) begin
                  mosi_d  = next_bit;
                  txcnt_d = txcnt_q + 4'd1;
               end
            end
         end
         S_XFER: begin
            if (term) begin
               if (edge_q == last_edge) begin
                  state_d = S_TRAIL;
                  cnt_d   = 8'd0;
                  sck_d   = cpol_q;
               end else begin
                  sck_d  = ~sck_q;
                  edge_d = edge_q + 6'd1;
                  // Next edge is a shift edge; CPHA=0 skips the shift on the final edge.
                  if ((edge_q[0] ^ cpha_q) && ((edge_q + 6'd1) != last_edge)) begin
                     mosi_d  = next_bit;
                     txcnt_d = txcnt_q + 4'd1;
                  end
               end
            end
         end
         S_TRAIL: begin
            if (term) begin
               state_d    = S_IDLE;
               cnt_d      = 8'd0;
               cs_d       = 1'b1;
               mosi_d     = 1'b0;
               rx_valid_d = 1'b1;
               rx_data_d  = dff_q ? rx_sh_q : {8'h00, rx_sh_q[7:0]};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         edge_q     <= 6'd0;
         txcnt_q    <= 4'd0;
         tx_q       <= 16'h0000;
         rx_sh_q    <= 16'h0000;
         rx_data_q  <= 16'h0000;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         br_q       <= 3'd0;
         dff_q      <= 1'b0;
         lsb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_q     <= edge_d;
         txcnt_q    <= txcnt_d;
         tx_q       <= tx_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         br_q       <= br_d;
         dff_q      <= dff_d;
         lsb_q      <= lsb_d;
      end
   end

   assign o_tx_ready = (state_q == S_IDLE);
   assign o_busy     = (state_q != S_IDLE);
   assign o_rx_valid = rx_valid_q;
   assign o_rx_data  = rx_data_q;
   assign SPI_SCK    = (state_q == S_IDLE) ? CPOL : sck_q;
   assign SPI_MOSI   = mosi_q;
   assign SPI_CS     = cs_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: directed and random frames against a protocol-level SPI slave/observer.
module tb_spi_shift_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        CPOL, CPHA, DFF, LSBFIRST;
   logic [2:0]  BR;
   logic [15:0] i_tx_data;
   logic        i_tx_valid;
   logic        o_tx_ready, o_rx_valid, o_busy;
   logic [15:0] o_rx_data;
   logic        SPI_SCK, SPI_MOSI, SPI_CS, SPI_MISO;
   logic        loopback, slave_bit;

   int checks   = 0;
   int failures = 0;

   assign SPI_MISO = loopback ? SPI_MOSI : slave_bit;

   always #5 clk = ~clk;

   spi_shift_engine dut (
      .clk        (clk),
      .rst        (rst),
      .CPOL       (CPOL),
      .CPHA       (CPHA),
      .BR         (BR),
      .DFF        (DFF),
      .LSBFIRST   (LSBFIRST),
      .i_tx_data  (i_tx_data),
      .i_tx_valid (i_tx_valid),
      .o_tx_ready (o_tx_ready),
      .o_rx_valid (o_rx_valid),
      .o_rx_data  (o_rx_data),
      .o_busy     (o_busy),
      .SPI_SCK    (SPI_SCK),
      .SPI_MOSI   (SPI_MOSI),
      .SPI_CS     (SPI_CS),
      .SPI_MISO   (SPI_MISO)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic word_bit(input logic [15:0] w, input int idx, input int n, input logic lsb);
      return lsb ? w[idx] : w[n-1-idx];
   endfunction

   // One frame observed from the wire. cont: accept already pending from a held request.
   task automatic run_frame(input string tag, input logic cpol, input logic cpha, input logic [2:0] br,
                            input logic dff, input logic lsb, input logic [15:0] data,
                            input logic [15:0] swd, input logic lb, input int poke_at,
                            input int rst_edge, input logic hold, input logic cont);
      int h, n, cs_low, edges, shifts, nsamp, rxv, timing_err, dir_err;
      logic prev_sck, done, aborted, leading;
      logic [15:0] mosi_word, mask, rx_seen, exp_rx;
      h = 1 << br;
      n = dff ? 16 : 8;
      mask = dff ? 16'hFFFF : 16'h00FF;
      exp_rx = (lb ? data : swd) & mask;
      if (!cont) @(negedge clk);
      CPOL = cpol; CPHA = cpha; BR = br; DFF = dff; LSBFIRST = lsb;
      i_tx_data = data; i_tx_valid = 1'b1; loopback = lb; slave_bit = 1'b0;
      @(negedge clk);
      if (!hold) i_tx_valid = 1'b0;
      done = 0; aborted = 0; cs_low = 0; edges = 0; nsamp = 0; rxv = 0;
      timing_err = 0; dir_err = 0; mosi_word = '0; rx_seen = '0;
      prev_sck = cpol;
      shifts = cpha ? 0 : 1;
      if (!cpha) slave_bit = word_bit(swd, 0, n, lsb);
      check({tag, "_cs_fall"}, {31'd0, SPI_CS}, 32'd0);
      check({tag, "_lead_sck"}, {31'd0, SPI_SCK}, {31'd0, cpol});
      for (int cyc = 0; cyc < 6000 && !done && !aborted; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (o_rx_valid) begin
            rxv++;
            rx_seen = o_rx_data;
         end
         if (SPI_CS) begin
            done = 1;
         end else begin
            cs_low++;
            if (SPI_SCK !== prev_sck) begin
               edges++;
               leading = (edges % 2) == 1;
               if (cyc != edges * h) timing_err++;
               if (SPI_SCK !== (leading ? ~cpol : cpol)) dir_err++;
               if (leading ^ cpha) begin
                  if (nsamp < n) mosi_word[lsb ? nsamp : n-1-nsamp] = SPI_MOSI;
                  nsamp++;
               end else begin
                  if (shifts < n) slave_bit = word_bit(swd, shifts, n, lsb);
                  shifts++;
               end
               prev_sck = SPI_SCK;
               if (edges == rst_edge) begin
                  rst = 1'b1;
                  #1;
                  check({tag, "_rst_cs"}, {31'd0, SPI_CS}, 32'd1);
                  check({tag, "_rst_busy"}, {31'd0, o_busy}, 32'd0);
                  check({tag, "_rst_rxv"}, {31'd0, o_rx_valid}, 32'd0);
                  aborted = 1;
               end
            end
            if (cyc == poke_at) begin
               i_tx_valid = 1'b1;
               BR = br + 3'd1;
            end else if (cyc == poke_at + 1) begin
               i_tx_valid = 1'b0;
            end
         end
      end
      if (!aborted) begin
         check({tag, "_end"}, {31'd0, done}, 32'd1);
         check({tag, "_cs_low"}, cs_low, h * (2 + 2 * n));
         check({tag, "_edges"}, edges, 2 * n);
         check({tag, "_edge_timing"}, timing_err, 0);
         check({tag, "_edge_dir"}, dir_err, 0);
         check({tag, "_mosi_word"}, {16'd0, mosi_word}, {16'd0, data & mask});
         check({tag, "_rxv_count"}, rxv, 1);
         check({tag, "_rx_data"}, {16'd0, rx_seen}, {16'd0, exp_rx});
         check({tag, "_idle_mosi"}, {31'd0, SPI_MOSI}, 32'd0);
         check({tag, "_idle_sck"}, {31'd0, SPI_SCK}, {31'd0, CPOL});
         check({tag, "_ready"}, {30'd0, o_tx_ready, o_busy}, 32'd2);
      end
   endtask

   initial begin
      logic       r_cpol, r_cpha, r_dff, r_lsb, r_lb;
      logic [2:0] r_br;
      logic [15:0] r_data, r_swd;

      rst = 1'b1; CPOL = 1'b1; CPHA = 1'b0; BR = 3'd0; DFF = 1'b0; LSBFIRST = 1'b0;
      i_tx_data = 16'hFFFF; i_tx_valid = 1'b1; loopback = 1'b1; slave_bit = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", {31'd0, SPI_CS}, 32'd1);
      check("rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
      check("rst_sck_cpol1", {31'd0, SPI_SCK}, 32'd1);
      check("rst_rxv", {31'd0, o_rx_valid}, 32'd0);
      check("rst_rxd", {16'd0, o_rx_data}, 32'd0);
      check("rst_no_accept", {31'd0, o_busy}, 32'd0);
      check("rst_ready", {31'd0, o_tx_ready}, 32'd1);
      CPOL = 1'b0;
      #1;
      check("idle_sck_live", {31'd0, SPI_SCK}, 32'd0);
      i_tx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {31'd0, o_busy}, 32'd0);

      run_frame("m0_a5", 0, 0, 3'd0, 0, 0, 16'h00A5, 16'h0000, 1, -1, 0, 0, 0);
      repeat (4) @(negedge clk);
      check("rxd_hold", {16'd0, o_rx_data}, 32'h00A5);

      run_frame("m3_1234", 1, 1, 3'd2, 1, 1, 16'h1234, 16'hBEEF, 0, -1, 0, 0, 0);
      run_frame("m1_3c", 0, 1, 3'd1, 0, 0, 16'h003C, 16'h0000, 1, -1, 0, 0, 0);
      run_frame("m2_3c", 1, 0, 3'd1, 0, 0, 16'h003C, 16'h0000, 1, -1, 0, 0, 0);

      run_frame("poke", 0, 0, 3'd1, 0, 0, 16'h0096, 16'h0000, 1, 10, 0, 0, 0);
      repeat (4) @(negedge clk);
      check("poke_no_queue", {31'd0, SPI_CS}, 32'd1);

      run_frame("rstmid", 0, 0, 3'd0, 0, 0, 16'h00C3, 16'h0000, 1, -1, 5, 0, 0);
      repeat (3) begin
         @(negedge clk);
         check("rstmid_no_rxv", {31'd0, o_rx_valid}, 32'd0);
      end
      check("rstmid_rxd_clear", {16'd0, o_rx_data}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rstmid_still_idle", {31'd0, SPI_CS}, 32'd1);
      run_frame("after_rst_5a", 0, 0, 3'd0, 0, 0, 16'h005A, 16'h0000, 1, -1, 0, 0, 0);

      run_frame("b2b_1", 0, 0, 3'd0, 0, 0, 16'h0081, 16'h0000, 1, -1, 0, 1, 0);
      run_frame("b2b_2", 0, 0, 3'd0, 0, 0, 16'h007E, 16'h0000, 1, -1, 0, 0, 1);

      for (int i = 0; i < 8; i++) begin
         r_cpol = 1'($urandom_range(0, 1));
         r_cpha = 1'($urandom_range(0, 1));
         r_dff  = 1'($urandom_range(0, 1));
         r_lsb  = 1'($urandom_range(0, 1));
         r_lb   = 1'($urandom_range(0, 1));
         r_br   = 3'($urandom_range(0, 3));
         r_data = 16'($urandom);
         r_swd  = 16'($urandom);
         run_frame($sformatf("rnd%0d", i), r_cpol, r_cpha, r_br, r_dff, r_lsb, r_data, r_swd,
                   r_lb, -1, 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
